// File: rtl/univ_shift_reg_pkg.sv
// Shared mode encodings for the universal shift register and its bench.
package univ_shift_reg_pkg;
    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_SHR  = 2'b01;
    localparam logic [1:0] MODE_SHL  = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;
endpackage

// File: rtl/usr_stage.sv
// One register bit: 4:1 mux (own / upper neighbour / lower neighbour / load data)
// into an async-reset flop with its own reset value.
module usr_stage
    import univ_shift_reg_pkg::*;
#(
    parameter logic RST_BIT = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] sel,
    input  logic       from_hi,
    input  logic       from_lo,
    input  logic       d,
    output logic       q
);
    logic nxt;

    // Unknown select falls to default so an X mode never corrupts the bit.
    always_comb begin
        nxt = q;
        case (sel)
            MODE_HOLD: nxt = q;
            MODE_SHR:  nxt = from_hi;
            MODE_SHL:  nxt = from_lo;
            MODE_LOAD: nxt = d;
            default:   nxt = q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) q <= RST_BIT;
        else     q <= nxt;
    end
endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register with shift counter and done pulse (serialiser use).
// Define USR_ROTATE_EN to add the rot port for rotate-instead-of-serial-in shifts.
module univ_shift_reg
    import univ_shift_reg_pkg::*;
#(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic [1:0]                 mode,
    input  logic                       sin_r,
    input  logic                       sin_l,
    input  logic [WIDTH-1:0]           d,
`ifdef USR_ROTATE_EN
    input  logic                       rot,
`endif
    output logic [WIDTH-1:0]           q,
    output logic                       sout_r,
    output logic                       sout_l,
    output logic [$clog2(WIDTH+1)-1:0] cnt,
    output logic                       done
);
    localparam int CW = $clog2(WIDTH+1);

    logic [1:0]       sel;
    logic             ser_r, ser_l;
    logic [WIDTH-1:0] hi_in, lo_in;

    // en=0 is folded into the select so the cells only ever see hold.
    assign sel = en ? mode : MODE_HOLD;

`ifdef USR_ROTATE_EN
    assign ser_r = rot ? q[0]       : sin_r;
    assign ser_l = rot ? q[WIDTH-1] : sin_l;
`else
    assign ser_r = sin_r;
    assign ser_l = sin_l;
`endif

    assign hi_in = {ser_r, q[WIDTH-1:1]};
    assign lo_in = {q[WIDTH-2:0], ser_l};

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        usr_stage #(.RST_BIT(RST_VAL[i])) u_stage (
            .clk     (clk),
            .rst     (rst),
            .sel     (sel),
            .from_hi (hi_in[i]),
            .from_lo (lo_in[i]),
            .d       (d[i]),
            .q       (q[i])
        );
    end

    assign sout_r = q[0];
    assign sout_l = q[WIDTH-1];

    // Count saturates at WIDTH; done marks only the WIDTH-1 -> WIDTH step.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            if (en) begin
                case (mode)
                    MODE_SHR, MODE_SHL: begin
                        if (cnt != CW'(WIDTH)) cnt <= cnt + 1'b1;
                        done <= (cnt == CW'(WIDTH-1));
                    end
                    MODE_LOAD: cnt <= '0;
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed self-checking bench for univ_shift_reg (WIDTH=8); second instance checks RST_VAL.
module tb_univ_shift_reg;
    import univ_shift_reg_pkg::*;

    logic       clk = 1'b0;
    logic       rst, en, sin_r, sin_l, rot;
    logic [1:0] mode;
    logic [7:0] d;
    logic [7:0] q, q2;
    logic       sout_r, sout_l, sout_r2, sout_l2, done, done2;
    logic [3:0] cnt, cnt2;

    int checks = 0;
    int errors = 0;

    univ_shift_reg #(.WIDTH(8), .RST_VAL(8'h00)) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .sin_r(sin_r), .sin_l(sin_l), .d(d),
`ifdef USR_ROTATE_EN
        .rot(rot),
`endif
        .q(q), .sout_r(sout_r), .sout_l(sout_l), .cnt(cnt), .done(done)
    );

    univ_shift_reg #(.WIDTH(8), .RST_VAL(8'hA5)) dut_a5 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .sin_r(sin_r), .sin_l(sin_l), .d(d),
`ifdef USR_ROTATE_EN
        .rot(rot),
`endif
        .q(q2), .sout_r(sout_r2), .sout_l(sout_l2), .cnt(cnt2), .done(done2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and land 1 ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [7:0] v);
        en = 1'b1; mode = MODE_LOAD; d = v;
        step();
    endtask

    logic [7:0] sr_seq;

    initial begin
        rst = 1'b1; en = 1'b0; mode = MODE_HOLD; sin_r = 1'b0; sin_l = 1'b0; d = '0; rot = 1'b0;
        sr_seq = 8'b1011_0010;

        // 1. reset before any clock edge
        #2;
        chk("rst_q", q, 8'h00);
        chk("rst_cnt", cnt, 0);
        chk("rst_done", done, 0);
        chk("rst_q_a5", q2, 8'hA5);
        rst = 1'b0;
        step();
        chk("en0_hold", q, 8'h00);

        // 2. load then hold
        load(8'h3C);
        chk("load_q", q, 8'h3C);
        chk("load_cnt", cnt, 0);
        mode = MODE_HOLD;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("hold_q", q, 8'h3C);
            chk("hold_done", done, 0);
        end

        // 3. serialise right
        load(8'hB2);
        mode = MODE_SHR; sin_r = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk("ser_sout_r", sout_r, sr_seq[i]);
            step();
            chk("ser_done", done, (i == 7) ? 1 : 0);
        end
        chk("ser_q", q, 8'h00);
        chk("ser_cnt", cnt, 8);
        step();
        chk("sat_cnt", cnt, 8);
        chk("sat_done", done, 0);

        // 4. shift left with enable gaps
        load(8'h01);
        mode = MODE_SHL; sin_l = 1'b1;
        for (int i = 0; i < 6; i++) begin
            en = (i % 2 == 0);
            step();
        end
        en = 1'b1;
        chk("shl_q", q, 8'h0F);
        chk("shl_cnt", cnt, 3);

        // sout_l follows q[7]
        load(8'h80);
        chk("sout_l", sout_l, 1);
        chk("sout_r", sout_r, 0);

        // undefined mode must not disturb q or cnt
        mode = 2'bxx;
        step();
        chk("x_mode_q", q, 8'h80);
        chk("x_mode_cnt", cnt, 0);

        // 5a. load collides with the would-be done edge
        load(8'h00);
        mode = MODE_SHR; sin_r = 1'b1;
        for (int i = 0; i < 7; i++) step();
        chk("pre_col_cnt", cnt, 7);
        load(8'hFF);
        chk("col_q", q, 8'hFF);
        chk("col_cnt", cnt, 0);
        chk("col_done", done, 0);

        // 5b. mid-shift asynchronous reset
        mode = MODE_SHL; sin_l = 1'b0;
        for (int i = 0; i < 4; i++) step();
        chk("pre_rst_cnt", cnt, 4);
        chk("pre_rst_q", q, 8'hF0);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_q", q, 8'h00);
        chk("mid_rst_cnt", cnt, 0);
        chk("mid_rst_q_a5", q2, 8'hA5);
        #1 rst = 1'b0;
        mode = MODE_HOLD;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("post_rst_done", done, 0);
        end
        chk("post_rst_cnt", cnt, 0);

`ifdef USR_ROTATE_EN
        // 6. rotate right
        load(8'h81);
        mode = MODE_SHR; rot = 1'b1; sin_r = 1'b0;
        step();
        chk("rot_q1", q, 8'hC0);
        for (int i = 1; i < 8; i++) begin
            chk("rot_nodone", done, 0);
            step();
        end
        chk("rot_q8", q, 8'h81);
        chk("rot_done", done, 1);
        chk("rot_cnt", cnt, 8);
        rot = 1'b0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
